// File: rtl/bypass_pipe.sv
// bypass_pipe: delay line carrying the per-pixel 'et' flag and LANES ql words
// alongside the main datapath. It tracks a valid bit per stage, advances or holds
// on a global enable, clears synchronously on flush, and reports how many valid
// entries are in flight. The outputs come straight from the last stage registers.
module bypass_pipe #(
    parameter int              DEPTH = 11,
    parameter int              LANES = 8,
    parameter int              QW    = 4,
    parameter logic [QW-1:0]   QRST  = {QW{1'b1}},
    parameter logic            ETRST = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_adv,
    input  logic                           i_flush,
    input  logic                           i_vld,
    input  logic                           i_et,
    input  logic [1:LANES][QW-1:0]         i_ql,
    output logic                           o_vld,
    output logic                           o_et,
    output logic [1:LANES][QW-1:0]         o_ql,
    output logic [$clog2(DEPTH+1)-1:0]     o_cnt,
    output logic                           o_busy
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [1:LANES][QW-1:0] ql_t;

    localparam ql_t QL_BUBBLE = {LANES{QRST}};

    logic          vld_q [1:DEPTH];
    logic          et_q  [1:DEPTH];
    ql_t           ql_q  [1:DEPTH];
    logic [CW-1:0] cnt_q;

    logic          et_in;
    ql_t           ql_in;

    // Stage 1 payload: an invalid input enters as a bubble, never as raw data.
    always_comb begin
        et_in = i_vld ? i_et : ETRST;
        ql_in = i_vld ? i_ql : QL_BUBBLE;
    end

    // Stage registers: reset/flush load bubbles, advance shifts by one, else hold.
    // NOTE: the payload registers are reset as well, not just the valid bits,
    // because the outputs must show the bubble values after reset or flush.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                vld_q[k] <= 1'b0;
                et_q[k]  <= ETRST;
                ql_q[k]  <= QL_BUBBLE;
            end
        end else if (i_adv) begin
            vld_q[1] <= i_vld;
            et_q[1]  <= et_in;
            ql_q[1]  <= ql_in;
            // NOTE: non-blocking assignments make every stage read its neighbour's
            // value from before this edge, so the whole line shifts exactly one place.
            for (int k = 2; k <= DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                et_q[k]  <= et_q[k-1];
                ql_q[k]  <= ql_q[k-1];
            end
        end
    end

    // Occupancy: +1 for a valid entry entering, -1 for a valid entry leaving.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            cnt_q <= '0;
        end else if (i_adv) begin
            cnt_q <= cnt_q + CW'(i_vld) - CW'(vld_q[DEPTH]);
        end
    end

    // Outputs are the last stage and the count register, with no input bypass.
    always_comb begin
        o_vld  = vld_q[DEPTH];
        o_et   = et_q[DEPTH];
        o_ql   = ql_q[DEPTH];
        o_cnt  = cnt_q;
        o_busy = (cnt_q != '0);
    end

endmodule

// File: tb/tb_bypass_pipe.sv
// Testbench for bypass_pipe: a default instance (DEPTH=11, LANES=8, QW=4) driven
// from a vector table plus streaming/flush/reset sequences, and a DEPTH=1,
// LANES=2, QW=6, QRST=6'h2A instance checking latency 1 and its reset value.
module tb_bypass_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Default instance
    logic            rst, adv, flush, vld, et;
    logic [1:8][3:0] ql;
    logic            o_vld, o_et, o_busy;
    logic [1:8][3:0] o_ql;
    logic [3:0]      o_cnt;

    bypass_pipe dut (
        .clk(clk), .rst(rst), .i_adv(adv), .i_flush(flush), .i_vld(vld),
        .i_et(et), .i_ql(ql), .o_vld(o_vld), .o_et(o_et), .o_ql(o_ql),
        .o_cnt(o_cnt), .o_busy(o_busy)
    );

    // DEPTH=1 instance
    logic            s_rst, s_adv, s_flush, s_vld, s_et;
    logic [1:2][5:0] s_ql;
    logic            s_o_vld, s_o_et, s_o_busy;
    logic [1:2][5:0] s_o_ql;
    logic [0:0]      s_o_cnt;

    bypass_pipe #(.DEPTH(1), .LANES(2), .QW(6), .QRST(6'h2A), .ETRST(1'b0)) dut_s (
        .clk(clk), .rst(s_rst), .i_adv(s_adv), .i_flush(s_flush), .i_vld(s_vld),
        .i_et(s_et), .i_ql(s_ql), .o_vld(s_o_vld), .o_et(s_o_et), .o_ql(s_o_ql),
        .o_cnt(s_o_cnt), .o_busy(s_o_busy)
    );

    localparam logic [31:0] BUB_QL = 32'hFFFF_FFFF;
    localparam logic [31:0] JUNK   = 32'hABCD_ABCD;

    typedef struct {
        string       name;
        logic        rst, adv, flush, vld, et;
        logic [31:0] ql;
        logic        evld, eet;
        logic [31:0] eql;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t tab[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic a, input logic f,
                                input logic v, input logic e, input logic [31:0] q,
                                input logic ev, input logic ee, input logic [31:0] eq,
                                input logic [3:0] ec);
        vec_t t;
        t.name = name; t.rst = r; t.adv = a; t.flush = f; t.vld = v; t.et = e; t.ql = q;
        t.evld = ev; t.eet = ee; t.eql = eq; t.ecnt = ec;
        return t;
    endfunction

    // Apply one vector for one clock edge, then compare all outputs.
    task automatic run_vec(input vec_t v);
        rst = v.rst; adv = v.adv; flush = v.flush; vld = v.vld; et = v.et; ql = v.ql;
        @(posedge clk);
        #1;
        check({v.name, ".vld"},  32'(o_vld),  32'(v.evld));
        check({v.name, ".et"},   32'(o_et),   32'(v.eet));
        check({v.name, ".ql"},   o_ql,        v.eql);
        check({v.name, ".cnt"},  32'(o_cnt),  32'(v.ecnt));
        check({v.name, ".busy"}, 32'(o_busy), 32'(v.ecnt != 0));
    endtask

    // Same for the DEPTH=1 instance.
    task automatic run_s(input string name, input logic a, input logic f, input logic v,
                         input logic e, input logic [11:0] q, input logic ev,
                         input logic ee, input logic [11:0] eq, input logic ec);
        s_adv = a; s_flush = f; s_vld = v; s_et = e; s_ql = q;
        @(posedge clk);
        #1;
        check({name, ".vld"},  32'(s_o_vld),  32'(ev));
        check({name, ".et"},   32'(s_o_et),   32'(ee));
        check({name, ".ql"},   32'(s_o_ql),   32'(eq));
        check({name, ".cnt"},  32'(s_o_cnt),  32'(ec));
        check({name, ".busy"}, 32'(s_o_busy), 32'(ec));
    endtask

    function automatic logic [31:0] idx_ql(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b[3:0], b[7:4], 24'h000321};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: reset, single entry, stalled entry, hold with valid at output.
        tab.push_back(mk("rst0",  1, 1, 0, 1, 1, JUNK, 0, 0, BUB_QL, 0));
        tab.push_back(mk("rst1",  1, 1, 0, 1, 1, JUNK, 0, 0, BUB_QL, 0));
        tab.push_back(mk("idle",  0, 0, 0, 1, 1, JUNK, 0, 0, BUB_QL, 0));
        tab.push_back(mk("t2_in", 0, 1, 0, 1, 1, 32'h1234_5678, 0, 0, BUB_QL, 1));
        for (int i = 2; i <= 10; i++)
            tab.push_back(mk("t2_fly", 0, 1, 0, 0, 1, JUNK, 0, 0, BUB_QL, 1));
        tab.push_back(mk("t2_out", 0, 1, 0, 0, 1, JUNK, 1, 1, 32'h1234_5678, 1));
        tab.push_back(mk("t2_end", 0, 1, 0, 0, 1, JUNK, 0, 0, BUB_QL, 0));
        tab.push_back(mk("t3_in", 0, 1, 0, 1, 1, 32'h8765_4321, 0, 0, BUB_QL, 1));
        for (int i = 2; i <= 4; i++)
            tab.push_back(mk("t3_fly", 0, 1, 0, 0, 0, JUNK, 0, 0, BUB_QL, 1));
        for (int i = 5; i <= 7; i++)
            tab.push_back(mk("t3_stall", 0, 0, 0, 1, 1, JUNK, 0, 0, BUB_QL, 1));
        for (int i = 8; i <= 13; i++)
            tab.push_back(mk("t3_fly2", 0, 1, 0, 0, 1, JUNK, 0, 0, BUB_QL, 1));
        tab.push_back(mk("t3_out",  0, 1, 0, 0, 1, JUNK, 1, 1, 32'h8765_4321, 1));
        tab.push_back(mk("t3_hold", 0, 0, 0, 1, 0, JUNK, 1, 1, 32'h8765_4321, 1));
        tab.push_back(mk("t3_end",  0, 1, 0, 0, 1, JUNK, 0, 0, BUB_QL, 0));

        rst = 1; adv = 0; flush = 0; vld = 0; et = 0; ql = '0;
        s_rst = 1; s_adv = 0; s_flush = 0; s_vld = 0; s_et = 0; s_ql = '0;

        foreach (tab[n]) run_vec(tab[n]);
        s_rst = 0;

        // Stream 20 entries then drain: count ramps, outputs show 0..19 in order.
        for (int s = 1; s <= 32; s++) begin
            int lo, hi, c, j;
            logic ev;
            lo = (s - 11 > 0) ? s - 11 : 0;
            hi = (s - 1 < 19) ? s - 1 : 19;
            c  = (hi >= lo) ? hi - lo + 1 : 0;
            j  = s - 11;
            ev = (j >= 0 && j <= 19);
            run_vec(mk("t4_stream", 0, 1, 0, (s <= 20), (s <= 20) ? 1'((s - 1) % 2) : 1'b1,
                       (s <= 20) ? idx_ql(s - 1) : JUNK,
                       ev, ev ? 1'(j % 2) : 1'b0, ev ? idx_ql(j) : BUB_QL, 4'(c)));
        end

        // Refill to a full pipe, then flush with a valid input on an advancing cycle.
        for (int s = 1; s <= 11; s++)
            run_vec(mk("t5_fill", 0, 1, 0, 1, 1, idx_ql(100 + s), s == 11, s == 11,
                       (s == 11) ? idx_ql(101) : BUB_QL, 4'(s)));
        run_vec(mk("t5_flush", 0, 1, 1, 1, 1, 32'h5A5A_5A5A, 0, 0, BUB_QL, 0));
        for (int s = 1; s <= 12; s++)
            run_vec(mk("t5_after", 0, 1, 0, 0, 1, JUNK, 0, 0, BUB_QL, 0));

        // Reset mid-stream at occupancy 5, then confirm nothing in flight emerges.
        for (int s = 1; s <= 5; s++)
            run_vec(mk("t6_fill", 0, 1, 0, 1, 1, idx_ql(200 + s), 0, 0, BUB_QL, 4'(s)));
        run_vec(mk("t6_rst", 1, 1, 0, 1, 1, JUNK, 0, 0, BUB_QL, 0));
        for (int s = 1; s <= 12; s++)
            run_vec(mk("t6_after", 0, 1, 0, 0, 1, JUNK, 0, 0, BUB_QL, 0));
        adv = 0;

        // DEPTH=1 instance: reset value, latency 1, simultaneous in/out, hold, bubble.
        check("s_rst.ql",  32'(s_o_ql),  32'h0000_0AAA);
        check("s_rst.vld", 32'(s_o_vld), 32'h0);
        check("s_rst.cnt", 32'(s_o_cnt), 32'h0);
        run_s("s_lat1",   1, 0, 1, 1, {6'h11, 6'h22}, 1, 1, {6'h11, 6'h22}, 1);
        run_s("s_inout",  1, 0, 1, 0, {6'h3F, 6'h01}, 1, 0, {6'h3F, 6'h01}, 1);
        run_s("s_hold",   0, 0, 1, 1, {6'h05, 6'h06}, 1, 0, {6'h3F, 6'h01}, 1);
        run_s("s_bubble", 1, 0, 0, 1, {6'h07, 6'h08}, 0, 0, 12'hAAA, 0);
        run_s("s_load",   1, 0, 1, 1, {6'h09, 6'h0A}, 1, 1, {6'h09, 6'h0A}, 1);
        run_s("s_flush",  1, 1, 1, 1, {6'h0B, 6'h0C}, 0, 0, 12'hAAA, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
